// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM port: channel modes, register select codes,
// bus width and the per-channel drive rule.
package led_pwm_pkg;

  localparam int DATA_W = 8;

  localparam logic SEL_DUTY = 1'b0;
  localparam logic SEL_MODE = 1'b1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Logical (pre-inversion) drive of one channel.
  function automatic logic channel_on(input mode_e mode, input logic pwm_hit, input logic blink);
    logic on;
    on = 1'b0;
    case (mode)
      MODE_OFF:   on = 1'b0;
      MODE_ON:    on = 1'b1;
      MODE_PWM:   on = pwm_hit;
      MODE_BLINK: on = pwm_hit & blink;
      default:    on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared time base: prescaler, PWM step counter and free-running period counter
// whose upper bit provides the blink phase.
module pwm_timebase #(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 188,
  parameter int BLINK_SHIFT = 8
) (
  input  logic                clk_48mhz,
  input  logic                reset,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_wrap,
  output logic                blink_phase
);

  localparam int PERW = BLINK_SHIFT + 1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PERW-1:0]     period_q, period_d;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int PSW = $clog2(PRESCALE);
      localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

      logic [PSW-1:0] presc_q, presc_d;

      assign tick = (presc_q == PS_LAST);

      always_comb begin
        presc_d = presc_q + PSW'(1);
        if (tick) begin
          presc_d = '0;
        end
      end

      always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_d;
        end
      end
    end
  endgenerate

  assign period_wrap = tick && (pwm_cnt_q == '1);
  assign blink_phase = period_q[BLINK_SHIFT];
  assign pwm_cnt     = pwm_cnt_q;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    period_d  = period_q;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
    if (period_wrap) begin
      period_d = period_q + PERW'(1);
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      period_q  <= period_d;
    end
  end

endmodule

// File: rtl/led_pwm_port.sv
// Multi-channel LED driver: per-channel double-buffered PWM duty and mode
// registers behind a small read/write port, with registered, optionally inverted pins.
module led_pwm_port
  import led_pwm_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  PWM_BITS    = 8,
  parameter int                  PRESCALE    = 188,
  parameter int                  BLINK_SHIFT = 8,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0
) (
  input  logic                       clk_48mhz,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [$clog2(CHANNELS):0]  addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [CHANNELS-1:0]        port_out
);

  localparam int AW = $clog2(CHANNELS) + 1;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                sel;
  logic [IW-1:0]       idx;
  logic                idx_valid;

  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_wrap;
  logic                blink_phase;

  logic [PWM_BITS-1:0] duty_sh_q  [CHANNELS];
  logic [PWM_BITS-1:0] duty_sh_d  [CHANNELS];
  logic [PWM_BITS-1:0] duty_act_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_act_d [CHANNELS];
  mode_e               mode_q     [CHANNELS];
  mode_e               mode_d     [CHANNELS];

  logic [CHANNELS-1:0] pwm_hit;
  logic [CHANNELS-1:0] on_vec;
  logic [CHANNELS-1:0] port_out_q, port_out_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  assign sel = addr[AW-1];

  generate
    if (CHANNELS > 1) begin : g_idx
      assign idx = addr[AW-2:0];
    end else begin : g_idx_single
      assign idx = '0;
    end

    // Only a non-power-of-two channel count leaves unused index codes.
    if ((1 << IW) == CHANNELS) begin : g_idx_full
      assign idx_valid = 1'b1;
    end else begin : g_idx_range
      assign idx_valid = (idx < IW'(CHANNELS));
    end
  endgenerate

  pwm_timebase #(
    .PWM_BITS    (PWM_BITS),
    .PRESCALE    (PRESCALE),
    .BLINK_SHIFT (BLINK_SHIFT)
  ) u_timebase (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .period_wrap (period_wrap),
    .blink_phase (blink_phase)
  );

  // Register writes; the active duty samples the pre-write shadow at the boundary.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      duty_act_d[i] = duty_act_q[i];
      mode_d[i]     = mode_q[i];
      if (wr_en && idx_valid && (idx == IW'(i))) begin
        if (sel == SEL_DUTY) begin
          duty_sh_d[i] = wr_data[PWM_BITS-1:0];
        end else begin
          mode_d[i] = mode_e'(wr_data[1:0]);
        end
      end
      if (tick && period_wrap) begin
        duty_act_d[i] = duty_sh_q[i];
      end
    end
  end

  // Full-scale duty is forced on so it never shows the single dark step.
  always_comb begin
    pwm_hit = '0;
    on_vec  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_hit[i] = (duty_act_q[i] == '1) || (pwm_cnt < duty_act_q[i]);
      on_vec[i]  = channel_on(mode_q[i], pwm_hit[i], blink_phase);
    end
    port_out_d = ACTIVE_LOW ^ on_vec;
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en && idx_valid) begin
      if (sel == SEL_DUTY) begin
        rd_data_d = DATA_W'(duty_sh_q[idx]);
      end else begin
        rd_data_d = DATA_W'(mode_q[idx]);
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
        mode_q[i]     <= MODE_OFF;
      end
      port_out_q <= ACTIVE_LOW;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
        mode_q[i]     <= mode_d[i];
      end
      port_out_q <= port_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign port_out = port_out_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_led_pwm_port.sv
// Directed plus randomized bench for led_pwm_port; expected pins and reads come
// from an arithmetic model of elapsed clock cycles since reset release.
module tb_led_pwm_port;

  localparam int          CH         = 8;
  localparam int          PS         = 2;
  localparam int          BS         = 2;
  localparam logic [7:0]  AL         = 8'h07;
  localparam int          PERIOD_CYC = PS * 256;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b0;
  logic       wr_en     = 1'b0;
  logic       rd_en     = 1'b0;
  logic [3:0] addr      = '0;
  logic [7:0] wr_data   = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] port_out;

  always #5 clk_48mhz = ~clk_48mhz;

  led_pwm_port #(
    .CHANNELS    (CH),
    .PWM_BITS    (8),
    .PRESCALE    (PS),
    .BLINK_SHIFT (BS),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .port_out  (port_out)
  );

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // clock edges since the last reset edge
  int sh  [CH];
  int act [CH];
  int md  [CH];
  int hi4, ones0, ones5;
  logic [7:0] got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pin state implied by the elapsed cycle count and the register contents.
  function automatic logic model_on(input int ch, input int cyc);
    int   steps = cyc / PS;
    int   pw    = steps % 256;
    int   per   = steps / 256;
    logic blink = (((per >> BS) & 1) == 1);
    logic lit   = (act[ch] == 255) || (pw < act[ch]);
    case (md[ch])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return lit;
      default: return lit && blink;
    endcase
  endfunction

  task automatic step();
    logic [7:0] exp_port;
    logic       exp_valid;
    logic [7:0] exp_rd;
    int         ch_i;
    exp_port = AL;
    exp_valid = 1'b0;
    exp_rd = 8'h00;
    if (!reset) begin
      n = 0;
      for (int i = 0; i < CH; i++) begin
        sh[i] = 0; act[i] = 0; md[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) exp_port[i] = AL[i] ^ model_on(i, n);
      exp_valid = rd_en;
      ch_i = int'(addr[2:0]);
      exp_rd = addr[3] ? 8'(md[ch_i]) : 8'(sh[ch_i]);
      n++;
      if (n % PERIOD_CYC == 0) begin
        for (int i = 0; i < CH; i++) act[i] = sh[i];
      end
      if (wr_en) begin
        if (addr[3]) md[ch_i] = int'(wr_data[1:0]);
        else         sh[ch_i] = int'(wr_data);
      end
    end
    @(posedge clk_48mhz);
    #1;
    chk("port_out", 32'(port_out), 32'(exp_port));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid || !reset) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    hi4   += int'(port_out[4]);
    ones0 += int'(port_out[0]);
    ones5 += int'(port_out[5]);
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic wait_boundary();
    while (n % PERIOD_CYC != 0) step();
  endtask

  task automatic wr(input logic sel, input int ch, input logic [7:0] d);
    wr_en = 1'b1; addr = {sel, 3'(ch)}; wr_data = d;
    $display("WR sel=%0d ch=%0d data=0x%02h", sel, ch, d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic sel, input int ch, output logic [7:0] val);
    rd_en = 1'b1; addr = {sel, 3'(ch)};
    step();
    val = rd_data;
    rd_en = 1'b0;
    $display("RD sel=%0d ch=%0d data=0x%02h valid=%0d", sel, ch, val, rd_valid);
  endtask

  initial begin
    hi4 = 0; ones0 = 0; ones5 = 0;

    reset = 1'b0;
    run(3);
    chk("reset_port", 32'(port_out), 32'h07);
    chk("reset_valid", 32'(rd_valid), 32'h0);
    reset = 1'b1;
    step();
    rd(1'b0, 0, got);
    chk("rd_after_reset", 32'(got), 32'h0);

    wr(1'b0, 4, 8'd64);
    wr(1'b1, 4, 8'd2);
    wait_boundary();
    hi4 = 0; run(PERIOD_CYC);
    chk("pwm64_high", 32'(hi4), 32'd128);

    hi4 = 0; run(100);
    wr(1'b0, 4, 8'd192);
    run(PERIOD_CYC - 101);
    chk("dbuf_current", 32'(hi4), 32'd128);
    hi4 = 0; run(PERIOD_CYC);
    chk("dbuf_next", 32'(hi4), 32'd384);

    wr(1'b1, 0, 8'd2);
    ones0 = 0; run(PERIOD_CYC);
    chk("duty0_pin", 32'(ones0), 32'(PERIOD_CYC));
    wr(1'b0, 0, 8'd255);
    wait_boundary();
    ones0 = 0; run(PERIOD_CYC);
    chk("duty255_pin", 32'(ones0), 32'd0);
    wr(1'b0, 0, 8'd0);
    wait_boundary();
    run(10);
    wr(1'b1, 0, 8'd1);
    ones0 = 0; run(200);
    chk("mode_on_pin", 32'(ones0), 32'd0);

    wr(1'b0, 5, 8'd255);
    wr(1'b1, 5, 8'd3);
    while (n % (PERIOD_CYC * 8) != 0) step();
    ones5 = 0; run(PERIOD_CYC * 4);
    chk("blink_off", 32'(ones5), 32'd0);
    ones5 = 0; run(PERIOD_CYC * 4);
    chk("blink_on", 32'(ones5), 32'(PERIOD_CYC * 4));

    wr(1'b0, 2, 8'h11);
    wr_en = 1'b1; rd_en = 1'b1; addr = {1'b0, 3'd2}; wr_data = 8'hAA;
    step();
    got = rd_data; wr_en = 1'b0; rd_en = 1'b0;
    $display("WR+RD sel=0 ch=2 data=0x%02h", got);
    chk("collision_old", 32'(got), 32'h11);
    rd(1'b0, 2, got);
    chk("read_new", 32'(got), 32'hAA);
    wr(1'b1, 2, 8'd3);
    rd(1'b1, 2, got);
    chk("mode_read_ch2", 32'(got), 32'h03);
    rd(1'b1, 4, got);
    chk("mode_read_ch4", 32'(got), 32'h02);

    rd_en = 1'b1; addr = {1'b0, 3'd4}; reset = 1'b0;
    step();
    rd_en = 1'b0; reset = 1'b1;
    step();
    chk("no_pending_valid", 32'(rd_valid), 32'h0);
    chk("port_after_abort", 32'(port_out), 32'h07);

    repeat (3000) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      rd_en   = ($urandom_range(0, 3) == 0);
      addr    = 4'($urandom);
      wr_data = 8'($urandom);
      reset   = ($urandom_range(0, 299) != 0);
      if (wr_en || rd_en)
        $display("RND wr=%0d rd=%0d addr=0x%0h data=0x%02h rst_n=%0d", wr_en, rd_en, addr, wr_data, reset);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; reset = 1'b1;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
